// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity modes
// and the data-width clamp limits.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BRK_WAIT
  } rx_state_t;

  typedef enum logic {
    PARITY_EVEN = 1'b0,
    PARITY_ODD  = 1'b1
  } parity_mode_t;

  localparam int DATA_BITS_MIN       = 5;
  localparam int DATA_BITS_MAX_LEGAL = 9;

  // Requested widths outside the supported range snap to the nearest limit.
  function automatic logic [3:0] clamp_data_bits(input logic [3:0] bits,
                                                 input logic [3:0] max_bits);
    if (bits < 4'(DATA_BITS_MIN)) return 4'(DATA_BITS_MIN);
    if (bits > max_bits) return max_bits;
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Metastability synchronizer for the serial line plus a 3-sample majority
// voter: two stored samples are voted with the live synchronized value.
module uart_rx_sampler #(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic sample_en,
  output logic rx_sync,
  output logic majority
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             samples_q;

  // Flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '1;
      samples_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (sample_en) begin
        samples_q <= {samples_q[0], sync_q[SYNC_STAGES-1]};
      end
    end
  end

  assign rx_sync  = sync_q[SYNC_STAGES-1];
  assign majority = (samples_q[1] & samples_q[0]) |
                    (samples_q[1] & rx_sync) |
                    (samples_q[0] & rx_sync);

endmodule

// File: rtl/uart_rx_engine.sv
// Oversampling UART receiver: latches the frame format at the start edge,
// votes each bit mid-period, and hands frames to a valid/ready output register.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int DIV_SIZE    = 16,
  parameter int DATA_MAX    = 9,
  parameter int SYNC_STAGES = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [3:0]          data_bits_i,
  input  logic                parity_en_i,
  input  logic                parity_odd_i,
  input  logic                stop_bits_i,
  input  logic [DIV_SIZE-1:0] baud_div_i,
  input  logic                rx_i,
  output logic [DATA_MAX-1:0] rx_data_o,
  output logic                rx_valid_o,
  input  logic                rx_ready_i,
  output logic                parity_err_o,
  output logic                frame_err_o,
  output logic                break_o,
  output logic                overrun_o,
  output logic                busy_o
);

  localparam logic [3:0] MAX_BITS = (DATA_MAX > DATA_BITS_MAX_LEGAL) ?
                                    4'(DATA_BITS_MAX_LEGAL) : 4'(DATA_MAX);

  rx_state_t            state_q, state_d;
  logic [DIV_SIZE-1:0]  cnt_q, cnt_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [DIV_SIZE-1:0]  baud_q, baud_d;
  logic [3:0]           nbits_q, nbits_d;
  logic                 par_en_q, par_en_d;
  parity_mode_t         par_mode_q, par_mode_d;
  logic                 two_stop_q, two_stop_d;
  logic [DATA_MAX-1:0]  shift_q, shift_d;
  logic                 par_acc_q, par_acc_d;
  logic                 stop_err_q, stop_err_d;
  logic                 all_zero_q, all_zero_d;
  logic                 frame_done;

  logic                 rx_sync;
  logic                 bit_val;
  logic                 sample_en;
  logic                 in_frame;
  logic [DIV_SIZE-1:0]  half;
  logic                 at_wrap;
  logic                 at_decide;

  logic [DATA_MAX-1:0]  load_data;
  logic                 load_perr;
  logic                 load_ferr;
  logic                 load_brk;

  uart_rx_sampler #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sampler (
    .clk      (clk_i),
    .rst      (rst_i),
    .rx       (rx_i),
    .sample_en(sample_en),
    .rx_sync  (rx_sync),
    .majority (bit_val)
  );

  assign in_frame  = state_q inside {START, DATA, PARITY, STOP1, STOP2};
  assign half      = baud_q >> 1;
  assign at_wrap   = (cnt_q == baud_q - 1'b1);
  assign at_decide = (cnt_q == half + 1'b1);
  assign sample_en = in_frame && ((cnt_q == half - 1'b1) || (cnt_q == half));
  assign busy_o    = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    nbits_d    = nbits_q;
    par_en_d   = par_en_q;
    par_mode_d = par_mode_q;
    two_stop_d = two_stop_q;
    shift_d    = shift_q;
    par_acc_d  = par_acc_q;
    stop_err_d = stop_err_q;
    all_zero_d = all_zero_q;
    frame_done = 1'b0;

    if (in_frame) begin
      cnt_d = at_wrap ? '0 : cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (en_i && !rx_sync) begin
          state_d    = START;
          cnt_d      = '0;
          bit_idx_d  = '0;
          baud_d     = baud_div_i;
          nbits_d    = clamp_data_bits(data_bits_i, MAX_BITS);
          par_en_d   = parity_en_i;
          par_mode_d = parity_mode_t'(parity_odd_i);
          two_stop_d = stop_bits_i;
          shift_d    = '0;
          par_acc_d  = 1'b0;
          stop_err_d = 1'b0;
          all_zero_d = 1'b1;
        end
      end
      START: begin
        if (at_decide && bit_val) begin
          state_d = IDLE;
        end else if (at_wrap) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (at_decide) begin
          shift_d    = shift_q | (DATA_MAX'(bit_val) << bit_idx_q);
          par_acc_d  = par_acc_q ^ bit_val;
          all_zero_d = all_zero_q & ~bit_val;
        end
        if (at_wrap) begin
          if (bit_idx_q == nbits_q - 4'd1) begin
            state_d = par_en_q ? PARITY : STOP1;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      PARITY: begin
        if (at_decide) begin
          par_acc_d  = par_acc_q ^ bit_val;
          all_zero_d = all_zero_q & ~bit_val;
        end
        if (at_wrap) begin
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (at_decide) begin
          stop_err_d = stop_err_q | ~bit_val;
          all_zero_d = all_zero_q & ~bit_val;
        end
        // The last stop bit completes at its decision point, not at bit end.
        if (!two_stop_q && at_decide) begin
          frame_done = 1'b1;
          state_d    = all_zero_d ? BRK_WAIT : IDLE;
        end else if (two_stop_q && at_wrap) begin
          state_d = STOP2;
        end
      end
      STOP2: begin
        if (at_decide) begin
          stop_err_d = stop_err_q | ~bit_val;
          all_zero_d = all_zero_q & ~bit_val;
          frame_done = 1'b1;
          state_d    = all_zero_d ? BRK_WAIT : IDLE;
        end
      end
      BRK_WAIT: begin
        if (rx_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (!en_i && (state_q != IDLE)) begin
      state_d    = IDLE;
      frame_done = 1'b0;
    end
  end

  // A break reports zero data and suppresses the parity flag.
  assign load_brk  = all_zero_d;
  assign load_data = all_zero_d ? '0 : shift_q;
  assign load_perr = !all_zero_d && par_en_q && (par_acc_q ^ (par_mode_q == PARITY_ODD));
  assign load_ferr = stop_err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      baud_q     <= '0;
      nbits_q    <= '0;
      par_en_q   <= 1'b0;
      par_mode_q <= PARITY_EVEN;
      two_stop_q <= 1'b0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      stop_err_q <= 1'b0;
      all_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      nbits_q    <= nbits_d;
      par_en_q   <= par_en_d;
      par_mode_q <= par_mode_d;
      two_stop_q <= two_stop_d;
      shift_q    <= shift_d;
      par_acc_q  <= par_acc_d;
      stop_err_q <= stop_err_d;
      all_zero_q <= all_zero_d;
    end
  end

  // An unaccepted frame is never overwritten; the newcomer is dropped instead.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      break_o      <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_o || rx_ready_i) begin
          rx_data_o    <= load_data;
          rx_valid_o   <= 1'b1;
          parity_err_o <= load_perr;
          frame_err_o  <= load_ferr;
          break_o      <= load_brk;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Self-checking bench for uart_rx_engine: table of fixed frames, hand-written
// corner sequences, then randomized frames against a frame-level model.
module tb_uart_rx_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] data_bits;
  logic       parity_en;
  logic       parity_odd;
  logic       stop_bits;
  logic [15:0] baud_div;
  logic       rx;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       parity_err;
  logic       frame_err;
  logic       break_flag;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int ovr_count = 0;

  typedef struct {
    logic [3:0] cfg_bits;
    int         tx_bits;
    logic [8:0] tx_data;
    bit         par_en;
    bit         par_odd;
    bit         par_bit;
    bit         two_stop;
    logic [1:0] stops;
    logic [8:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
    bit         exp_brk;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (overrun) ovr_count <= ovr_count + 1;
  end

  uart_rx_engine #(
    .DIV_SIZE(16),
    .DATA_MAX(9),
    .SYNC_STAGES(3)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .data_bits_i (data_bits),
    .parity_en_i (parity_en),
    .parity_odd_i(parity_odd),
    .stop_bits_i (stop_bits),
    .baud_div_i  (baud_div),
    .rx_i        (rx),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .parity_err_o(parity_err),
    .frame_err_o (frame_err),
    .break_o     (break_flag),
    .overrun_o   (overrun),
    .busy_o      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic drive_bit(input logic v, input int baud);
    rx = v;
    repeat (baud) @(negedge clk);
  endtask

  // Sends one frame; optionally scrambles the format inputs once the start bit is out.
  task automatic applyStimulus(input vec_t v, input int baud, input bit scramble);
    data_bits  = v.cfg_bits;
    parity_en  = v.par_en;
    parity_odd = v.par_odd;
    stop_bits  = v.two_stop;
    baud_div   = 16'(baud);
    @(negedge clk);
    drive_bit(1'b0, baud);
    if (scramble) begin
      data_bits  = 4'($urandom_range(0, 15));
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      stop_bits  = 1'($urandom_range(0, 1));
      baud_div   = 16'($urandom_range(4, 40));
    end
    for (int i = 0; i < v.tx_bits; i++) drive_bit(v.tx_data[i], baud);
    if (v.par_en) drive_bit(v.par_bit, baud);
    drive_bit(v.stops[0], baud);
    if (v.two_stop) drive_bit(v.stops[1], baud);
    rx = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!rx_valid && i < 64) begin
      @(negedge clk);
      i++;
    end
    checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int i = 0;
    while (busy && i < 2000) begin
      @(negedge clk);
      i++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input logic [8:0] ed, input bit ep,
                             input bit ef, input bit eb);
    wait_valid(tag);
    checkOutput({tag, "_data"}, 32'(rx_data), 32'(ed));
    checkOutput({tag, "_perr"}, 32'(parity_err), 32'(ep));
    checkOutput({tag, "_ferr"}, 32'(frame_err), 32'(ef));
    checkOutput({tag, "_brk"}, 32'(break_flag), 32'(eb));
  endtask

  task automatic accept_frame(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    checkOutput({tag, "_clear"}, 32'(rx_valid), 32'd0);
  endtask

  function automatic vec_t make_8n1(input logic [8:0] d);
    vec_t v;
    v = '{4'd8, 8, d, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, d, 1'b0, 1'b0, 1'b0};
    return v;
  endfunction

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    int   baud;
    int   nb;
    int   ovr_before;
    int   busy_cycles;
    bit   good_par;
    logic [8:0] mask;

    vecs[0] = '{4'd8,  8, 9'h0A5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd7,  7, 9'h035, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 9'h035, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{4'd9,  9, 9'h1C3, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 9'h1C3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'd3,  5, 9'h015, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'h015, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'd15, 9, 9'h12D, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 9'h12D, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{4'd8,  8, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd8,  8, 9'h000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 9'h000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{4'd6,  6, 9'h02A, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 9'h02A, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{4'd5,  5, 9'h01F, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 9'h01F, 1'b1, 1'b0, 1'b0};

    rst        = 1'b1;
    en         = 1'b1;
    rx         = 1'b1;
    rx_ready   = 1'b0;
    data_bits  = 4'd8;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop_bits  = 1'b0;
    baud_div   = 16'd16;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_data", 32'(rx_data), 32'd0);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_perr", 32'(parity_err), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_brk", 32'(break_flag), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    $display("[TB] fixed frame table");
    for (int k = 0; k < 9; k++) begin
      applyStimulus(vecs[k], 16, 1'b0);
      check_frame($sformatf("vec%0d", k), vecs[k].exp_data, vecs[k].exp_perr,
                  vecs[k].exp_ferr, vecs[k].exp_brk);
      accept_frame($sformatf("vec%0d", k));
      wait_idle($sformatf("vec%0d", k));
      repeat (4) @(negedge clk);
    end

    $display("[TB] false start");
    baud_div = 16'd16;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    busy_cycles = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) busy_cycles++;
    end
    checkOutput("false_start_seen", 32'(busy_cycles > 0), 32'd1);
    checkOutput("false_start_le10", 32'(busy_cycles <= 10), 32'd1);
    checkOutput("false_start_valid", 32'(rx_valid), 32'd0);
    checkOutput("false_start_busy", 32'(busy), 32'd0);

    $display("[TB] overrun");
    applyStimulus(make_8n1(9'h011), 16, 1'b0);
    check_frame("ovr_first", 9'h011, 1'b0, 1'b0, 1'b0);
    wait_idle("ovr_first");
    ovr_before = ovr_count;
    applyStimulus(make_8n1(9'h022), 16, 1'b0);
    wait_idle("ovr_second");
    repeat (20) @(negedge clk);
    checkOutput("ovr_pulses", 32'(ovr_count - ovr_before), 32'd1);
    checkOutput("ovr_kept_data", 32'(rx_data), 32'h011);
    checkOutput("ovr_kept_valid", 32'(rx_valid), 32'd1);
    accept_frame("ovr");

    $display("[TB] enable drop mid-frame");
    applyStimulus(make_8n1(9'h077), 16, 1'b0);
    check_frame("abort_prev", 9'h077, 1'b0, 1'b0, 1'b0);
    wait_idle("abort_prev");
    ovr_before = ovr_count;
    @(negedge clk);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 8);
    en = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (48) @(negedge clk);
    checkOutput("abort_valid", 32'(rx_valid), 32'd1);
    checkOutput("abort_data", 32'(rx_data), 32'h077);
    checkOutput("abort_no_ovr", 32'(ovr_count - ovr_before), 32'd0);
    accept_frame("abort");

    $display("[TB] break");
    rx = 1'b0;
    repeat (12 * 16) @(negedge clk);
    check_frame("break", 9'h000, 1'b0, 1'b1, 1'b1);
    checkOutput("break_wait_busy", 32'(busy), 32'd1);
    accept_frame("break");
    repeat (32) @(negedge clk);
    checkOutput("break_no_restart", 32'(rx_valid), 32'd0);
    checkOutput("break_still_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    wait_idle("break");
    repeat (20) @(negedge clk);
    checkOutput("break_after_high", 32'(rx_valid), 32'd0);

    $display("[TB] reset mid-frame");
    applyStimulus(make_8n1(9'h096), 16, 1'b0);
    check_frame("rst_prev", 9'h096, 1'b0, 1'b0, 1'b0);
    wait_idle("rst_prev");
    @(negedge clk);
    drive_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) drive_bit(((8'hC3 >> i) & 8'h01) != 0, 16);
    drive_bit(1'b0, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rx  = 1'b1;
    checkOutput("rst_mid_data", 32'(rx_data), 32'd0);
    checkOutput("rst_mid_valid", 32'(rx_valid), 32'd0);
    checkOutput("rst_mid_flags", 32'({parity_err, frame_err, break_flag, overrun}), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    applyStimulus(make_8n1(9'h05A), 16, 1'b0);
    check_frame("rst_next", 9'h05A, 1'b0, 1'b0, 1'b0);
    accept_frame("rst_next");
    wait_idle("rst_next");

    $display("[TB] randomized frames");
    ovr_before = ovr_count;
    for (int f = 0; f < 40; f++) begin
      baud       = $urandom_range(4, 24);
      v.cfg_bits = 4'($urandom_range(0, 15));
      nb         = (v.cfg_bits < 5) ? 5 : ((v.cfg_bits > 9) ? 9 : int'(v.cfg_bits));
      mask       = 9'((1 << nb) - 1);
      v.tx_bits  = nb;
      v.tx_data  = 9'($urandom) & mask;
      v.par_en   = 1'($urandom_range(0, 1));
      v.par_odd  = 1'($urandom_range(0, 1));
      v.two_stop = 1'($urandom_range(0, 1));
      good_par   = ($countones(v.tx_data) % 2 == 1) ^ v.par_odd;
      v.par_bit  = good_par ^ ($urandom_range(0, 3) == 0);
      v.stops    = 2'b11;
      if ($urandom_range(0, 6) == 0) v.stops[0] = 1'b0;
      if ($urandom_range(0, 6) == 0) v.stops[1] = 1'b0;
      if (v.tx_data == 9'd0 && (!v.par_en || !v.par_bit)) v.stops[0] = 1'b1;
      v.exp_data = v.tx_data;
      v.exp_perr = v.par_en && (v.par_bit != good_par);
      v.exp_ferr = !v.stops[0] || (v.two_stop && !v.stops[1]);
      v.exp_brk  = 1'b0;
      applyStimulus(v, baud, 1'b1);
      check_frame($sformatf("rnd%0d", f), v.exp_data, v.exp_perr, v.exp_ferr, v.exp_brk);
      accept_frame($sformatf("rnd%0d", f));
      wait_idle($sformatf("rnd%0d", f));
      repeat (3) @(negedge clk);
    end
    checkOutput("rnd_no_overrun", 32'(ovr_count - ovr_before), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
